crgu_dom_seq: RTL and testbench
===============================

// Module: crgu_dom_seq
// PURPOSE
//  Parametrised power-domain sequencer in the CRGU, clocked on the always-on register clock.
//  For each of NUM_DOM gated domains it orders the clock-gate enable and the sw_reset release/assert.
//  These outputs drive the genpart_ckgt enable and the genpart_rstn sw_reset of that domain.
//  Domains are sequenced one at a time, with round-robin fairness and programmable settle delays.
// PARAMETERS
//  NUM_DOM  4  number of sequenced domains (1..16)
//  CNT_W    8  width of settle-delay counters/config fields
// PORTS
//  clk_6p5m_reg     in   1        always-on 6.5M register clock
//  rst_reg_n        in   1        async active-low reset
//  scan_mode        in   1        1: force dom_clk_en_o all-ones (comb override, FSM unaffected)
//  dom_req          in   NUM_DOM  per-domain on request, level, clk_6p5m_reg domain
//  sys_off          in   1        1: effective target = 0 for all domains
//  rg_dly_up        in   CNT_W    cycles between clock enable and reset release
//  rg_dly_dn        in   CNT_W    cycles between reset assert and clock disable
//  dom_clk_en_o     out  NUM_DOM  clock-gate enable per domain
//  dom_sw_reset_o   out  NUM_DOM  sw_reset per domain, 1 = held in reset
//  dom_on_o         out  NUM_DOM  domain fully on (clock running, reset released)
//  busy_o           out  1        FSM not in IDLE
//  done_o           out  1        1-cycle pulse when a sequence completes
//  done_idx_o       out  4        index of domain whose sequence completed (valid with done_o)
// BEHAVIOUR
//  Reset values
//   - dom_clk_en_o = 0; dom_sw_reset_o = all-ones; dom_on_o = 0.
//   - busy_o = 0; done_o = 0; done_idx_o = 0.
//   - Round-robin pointer rr = 0; state = IDLE.
//  Target and mismatch
//   - tgt = dom_req & ~{NUM_DOM{sys_off}}.
//   - Domain i is mismatched when tgt[i] != dom_on_o[i].
//  States: IDLE, UP_WAIT, DN_WAIT.
//  IDLE: pick first mismatched i, searching from rr upward with wrap to 0; latch sel = i.
//   - Power-up (tgt=1): same edge sets dom_clk_en_o[i] = 1 and cnt = rg_dly_up -> UP_WAIT.
//   - Power-down (tgt=0): same edge sets dom_sw_reset_o[i] = 1, dom_on_o[i] = 0, cnt = rg_dly_dn -> DN_WAIT.
//   - No mismatch: stay in IDLE.
//  UP_WAIT: cnt != 0 -> cnt - 1. cnt == 0 -> at next edge:
//   - dom_sw_reset_o[sel] = 0, dom_on_o[sel] = 1.
//   - done_o = 1, done_idx_o = sel, rr = sel+1 (mod NUM_DOM) -> IDLE.
//  DN_WAIT: cnt != 0 -> cnt - 1. cnt == 0 -> at next edge:
//   - dom_clk_en_o[sel] = 0.
//   - done_o, done_idx_o, rr updated as in UP_WAIT -> IDLE.
//  Timing
//   - Clock-enable rise to reset release = rg_dly_up + 1 edges.
//   - Reset assert to clock-enable fall = rg_dly_dn + 1 edges.
//   - dom_req rise before edge E0 -> dom_clk_en_o high after E0 (from IDLE).
//   - Minimum one IDLE cycle between sequences.
//  Invariants
//   - dom_sw_reset_o[i] = 0 only while dom_clk_en_o[i] = 1; never 0 with clock gated.
//   - dom_on_o[i] = dom_clk_en_o[i] & ~dom_sw_reset_o[i].
//  Delay sampling: rg_dly_* are sampled only at load; mid-wait changes do not affect the running sequence.
//  Sequences are non-abortable
//   - A req change or sys_off mid-sequence does not abort it.
//   - The sequence completes, then IDLE re-evaluates the mismatch.
//  Simultaneous requests: serviced in round-robin order, one at a time.
//  Other rules
//   - Unselected domains hold their outputs.
//   - Reset mid-sequence: all outputs return to reset values immediately (async).
//   - NUM_DOM = 1: rr stays 0.
//   - Counter arithmetic is unsigned CNT_W; a delay of 0 is legal.
// TESTING
//  1. After reset, dom_req = 4'b0001, rg_dly_up = 3:
//     - dom_clk_en_o[0] rises 1 cycle after req.
//     - dom_sw_reset_o[0] falls 4 edges later, with done_o = 1 and done_idx_o = 0.
//  2. dom_req = 4'b1111 in one cycle, dly_up = 0: domains come up in order 0,1,2,3.
//     - Each is 3 edges apart (load, release, idle).
//     - Four done_o pulses.
//  3. With all on, sys_off = 1, rg_dly_dn = 5:
//     - Each domain: reset asserted, then clock enable falls 6 edges later.
//     - Order is round-robin from rr; dom_on_o ends at 0.
//  4. Drop dom_req[2] while domain 2 is in UP_WAIT:
//     - The up sequence completes (dom_on_o[2] = 1).
//     - A down sequence follows, ending at dom_clk_en_o[2] = 0.
//  5. Assert rst_reg_n low mid DN_WAIT:
//     - dom_clk_en_o = 0, dom_sw_reset_o = 4'b1111, busy_o = 0 immediately.
//     - scan_mode = 1 forces dom_clk_en_o = 4'b1111 while dom_sw_reset_o is unchanged.

Source files
------------

// File: rtl/crgu_dom_seq.sv
// crgu_dom_seq: power-domain sequencer on the always-on register clock.
// Each of NUM_DOM gated domains is brought up or down one at a time. Power-up
// order is clock enable, settle delay, then reset release. Power-down order is
// reset assert, settle delay, then clock disable. Pending domains are serviced
// round-robin.
// Ports:
//   clk_6p5m_reg   always-on register clock
//   rst_reg_n      async active-low reset
//   scan_mode      forces dom_clk_en_o to all-ones; the FSM is not affected
//   dom_req        per-domain on request (level)
//   sys_off        forces every domain's target to off
//   rg_dly_up      enable-to-release settle cycles, sampled when a sequence starts
//   rg_dly_dn      assert-to-disable settle cycles, sampled when a sequence starts
//   dom_clk_en_o   clock-gate enable per domain
//   dom_sw_reset_o sw_reset per domain (1 = held in reset)
//   dom_on_o       domain fully on
//   busy_o         a sequence is in progress
//   done_o         1-cycle pulse on sequence completion
//   done_idx_o     index of the completed domain, valid with done_o
module crgu_dom_seq #(
  parameter int unsigned NUM_DOM = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk_6p5m_reg,
  input  logic               rst_reg_n,
  input  logic               scan_mode,
  input  logic [NUM_DOM-1:0] dom_req,
  input  logic               sys_off,
  input  logic [CNT_W-1:0]   rg_dly_up,
  input  logic [CNT_W-1:0]   rg_dly_dn,
  output logic [NUM_DOM-1:0] dom_clk_en_o,
  output logic [NUM_DOM-1:0] dom_sw_reset_o,
  output logic [NUM_DOM-1:0] dom_on_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [3:0]         done_idx_o
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] UP_WAIT = 2'd1;
  localparam logic [1:0] DN_WAIT = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         sel;
  logic [3:0]         rr;
  logic [3:0]         rr_next;
  logic [NUM_DOM-1:0] clk_en_q;
  logic [NUM_DOM-1:0] tgt;
  logic [NUM_DOM-1:0] mism;
  logic [NUM_DOM-1:0] mism_sh;
  logic [NUM_DOM-1:0] pick_mask;
  logic [NUM_DOM-1:0] sel_mask;
  logic               found;
  logic               pick_up;
  logic [3:0]         pick;
  int unsigned        j;

  // First mismatched domain, searching upward from rr with wrap-around.
  always_comb begin
    tgt     = dom_req & ~{NUM_DOM{sys_off}};
    mism    = tgt ^ dom_on_o;
    found   = 1'b0;
    pick    = '0;
    j       = 0;
    mism_sh = '0;
    for (int unsigned k = 0; k < NUM_DOM; k++) begin
      j = 32'(rr) + k;
      if (j >= NUM_DOM) j = j - NUM_DOM;
      mism_sh = mism >> j;
      if (!found && mism_sh[0]) begin
        found = 1'b1;
        pick  = 4'(j);
      end
    end
    pick_mask = NUM_DOM'(1) << pick;
    sel_mask  = NUM_DOM'(1) << sel;
    pick_up   = |(tgt & pick_mask);
    rr_next   = (32'(sel) + 1 >= NUM_DOM) ? 4'd0 : sel + 4'd1;
  end

  always_ff @(posedge clk_6p5m_reg or negedge rst_reg_n) begin
    if (!rst_reg_n) begin
      state          <= IDLE;
      cnt            <= '0;
      sel            <= '0;
      rr             <= '0;
      clk_en_q       <= '0;
      dom_sw_reset_o <= '1;
      dom_on_o       <= '0;
      done_o         <= 1'b0;
      done_idx_o     <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle is spent idle so sequences are separated by one
          // dead cycle; the search resumes on the following edge.
          if (!done_o && found) begin
            sel <= pick;
            if (pick_up) begin
              clk_en_q <= clk_en_q | pick_mask;
              cnt      <= rg_dly_up;
              state    <= UP_WAIT;
            end else begin
              dom_sw_reset_o <= dom_sw_reset_o | pick_mask;
              dom_on_o       <= dom_on_o & ~pick_mask;
              cnt            <= rg_dly_dn;
              state          <= DN_WAIT;
            end
          end
        end
        UP_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            dom_sw_reset_o <= dom_sw_reset_o & ~sel_mask;
            dom_on_o       <= dom_on_o | sel_mask;
            done_o         <= 1'b1;
            done_idx_o     <= sel;
            rr             <= rr_next;
            state          <= IDLE;
          end
        end
        DN_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            clk_en_q   <= clk_en_q & ~sel_mask;
            done_o     <= 1'b1;
            done_idx_o <= sel;
            rr         <= rr_next;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dom_clk_en_o = clk_en_q | {NUM_DOM{scan_mode}};
  assign busy_o       = (state != IDLE);

endmodule

// File: tb/tb_crgu_dom_seq.sv
// Testbench for crgu_dom_seq (NUM_DOM = 4). The reference model tracks each
// sequence by the absolute edge number on which it completes.
module tb_crgu_dom_seq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         scan = 1'b0;
  logic [N-1:0] req = '0;
  logic         off = 1'b0;
  logic [7:0]   dly_up = '0;
  logic [7:0]   dly_dn = '0;
  logic [N-1:0] clk_en;
  logic [N-1:0] sw_rst;
  logic [N-1:0] dom_on;
  logic         busy;
  logic         done;
  logic [3:0]   done_idx;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] m_en, m_rst, m_on;
  bit m_act, m_up, m_gap, m_done;
  int m_sel, m_end, m_rr, m_idx, ecount;

  crgu_dom_seq #(.NUM_DOM(N), .CNT_W(8)) dut (
    .clk_6p5m_reg  (clk),
    .rst_reg_n     (rst_n),
    .scan_mode     (scan),
    .dom_req       (req),
    .sys_off       (off),
    .rg_dly_up     (dly_up),
    .rg_dly_dn     (dly_dn),
    .dom_clk_en_o  (clk_en),
    .dom_sw_reset_o(sw_rst),
    .dom_on_o      (dom_on),
    .busy_o        (busy),
    .done_o        (done),
    .done_idx_o    (done_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_en = '0; m_rst = '1; m_on = '0;
    m_act = 0; m_up = 0; m_gap = 0; m_done = 0;
    m_sel = 0; m_end = 0; m_rr = 0; m_idx = 0;
  endtask

  task automatic model_step();
    bit fnd;
    bit want;
    int jj;
    m_done = 0;
    if (m_act) begin
      if (ecount == m_end) begin
        if (m_up) begin
          m_rst[m_sel] = 1'b0;
          m_on[m_sel]  = 1'b1;
        end else begin
          m_en[m_sel] = 1'b0;
        end
        m_done = 1; m_idx = m_sel; m_rr = (m_sel + 1) % N;
        m_act = 0; m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      fnd = 0;
      for (int k = 0; k < N; k++) begin
        jj = (m_rr + k) % N;
        want = req[jj] & ~off;
        if (!fnd && want != m_on[jj]) begin
          fnd = 1; m_act = 1; m_sel = jj; m_up = want;
          if (want) begin
            m_en[jj] = 1'b1;
            m_end = ecount + int'(dly_up) + 1;
          end else begin
            m_rst[jj] = 1'b1;
            m_on[jj]  = 1'b0;
            m_end = ecount + int'(dly_dn) + 1;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    chk("clk_en", 32'(clk_en), scan ? 32'hF : 32'(m_en));
    chk("sw_reset", 32'(sw_rst), 32'(m_rst));
    chk("dom_on", 32'(dom_on), 32'(m_on));
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(m_done));
    if (m_done) chk("done_idx", 32'(done_idx), 32'(m_idx));
  endtask

  task automatic tick();
    @(posedge clk);
    ecount++;
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int guard;
    model_reset();
    ecount = 0;
    #12;
    check_all();
    chk("rst_done_idx", 32'(done_idx), 32'h0);
    rst_n = 1'b1;

    // 1: single domain power-up with a 3-cycle settle
    dly_up = 8'd3; dly_dn = 8'd2;
    tick();
    req = 4'b0001;
    tick();
    chk("t1_en_after_req", 32'(clk_en[0]), 32'h1);
    repeat (3) tick();
    chk("t1_still_reset", 32'(sw_rst[0]), 32'h1);
    tick();
    chk("t1_release", 32'(sw_rst[0]), 32'h0);
    chk("t1_done", 32'(done), 32'h1);
    repeat (3) tick();

    // 2: all domains at once, zero delay
    dly_up = 8'd0;
    req = 4'b1111;
    repeat (12) tick();
    chk("t2_all_on", 32'(dom_on), 32'hF);

    // 3: system off, 5-cycle settle
    off = 1'b1; dly_dn = 8'd5;
    repeat (34) tick();
    chk("t3_all_off", 32'(dom_on | clk_en), 32'h0);

    // 4: drop req[2] while domain 2 is powering up
    off = 1'b0; dly_up = 8'd4; req = 4'b1111;
    guard = 0;
    while (!(m_act && m_up && m_sel == 2) && guard < 80) begin
      tick(); guard++;
    end
    chk("t4_reach_up2", 32'(guard < 80), 32'h1);
    tick();
    req = 4'b1011;
    repeat (50) tick();
    chk("t4_dom2_off", 32'({clk_en[2], dom_on[2]}), 32'h0);
    chk("t4_others_on", 32'(dom_on), 32'hB);

    // 5: async reset mid power-down, then scan override
    off = 1'b1; dly_dn = 8'd8;
    guard = 0;
    while (!(m_act && !m_up) && guard < 40) begin
      tick(); guard++;
    end
    chk("t5_reach_dn", 32'(guard < 40), 32'h1);
    repeat (2) tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_en", 32'(clk_en), 32'h0);
    chk("t5_rst_sw", 32'(sw_rst), 32'hF);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    check_all();
    scan = 1'b1;
    #1;
    chk("t5_scan_en", 32'(clk_en), 32'hF);
    chk("t5_scan_sw", 32'(sw_rst), 32'hF);
    scan = 1'b0;
    #1 rst_n = 1'b1;
    off = 1'b0; req = '0;
    tick();

    // Random phase
    for (int c = 0; c < 700; c++) begin
      if ($urandom_range(7, 0) == 0) req = N'($urandom);
      if ($urandom_range(15, 0) == 0) off = ($urandom_range(3, 0) == 0);
      if ($urandom_range(3, 0) == 0) dly_up = 8'($urandom_range(4, 0));
      if ($urandom_range(3, 0) == 0) dly_dn = 8'($urandom_range(4, 0));
      scan = ($urandom_range(9, 0) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
